// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle arithmetic/logic/shift ops,
// a shift-add multiplier and an optional restoring divider.
// Build option: define ALU_DIV_EN to include the divu datapath; without it
// func 011011 decodes as an illegal operation.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluop,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
    OP_SLL, OP_SRL, OP_SRA, OP_MULTU, OP_DIVU, OP_ILL
  } op_t;

  state_t state, state_next;
  op_t dec_op;

  logic             ready_armed;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] op_q;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
`ifdef ALU_DIV_EN
  logic             busy_div;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
`endif

  // Requests are only taken in IDLE, and never before the first edge after reset.
  assign in_ready = ready_armed && (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Map the main-decoder op class and R-type func field onto one internal op.
  always_comb begin
    dec_op = OP_ILL;
    case (aluop)
      3'b000: dec_op = OP_ADD;
      3'b001: dec_op = OP_SUB;
      3'b010: dec_op = OP_AND;
      3'b011: dec_op = OP_OR;
      3'b100: dec_op = OP_SLT;
      default: begin
        case (func)
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b101010: dec_op = OP_SLT;
          6'b000000: dec_op = OP_SLL;
          6'b000010: dec_op = OP_SRL;
          6'b000011: dec_op = OP_SRA;
          6'b011001: dec_op = OP_MULTU;
`ifdef ALU_DIV_EN
          6'b011011: dec_op = OP_DIVU;
`endif
          default:   dec_op = OP_ILL;
        endcase
      end
    endcase
  end

  // Single-cycle result straight from the request operands; illegal yields 0.
  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD: alu_res = a + b;
      OP_SUB: alu_res = a - b;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      OP_SRA: alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply, or of restoring divide when dividing.
  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_q} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, op_q};
    if (busy_div) begin
      if (!div_diff[WIDTH+1]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state: multi-cycle ops go through BUSY, everything else straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = DONE;
          if (dec_op == OP_MULTU) state_next = BUSY;
`ifdef ALU_DIV_EN
          if (dec_op == OP_DIVU && b != '0) state_next = BUSY;
`endif
        end
      end
      BUSY: if (count == LAST_STEP) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs; results only change on accept or the final iteration.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_armed <= 1'b0;
      out_valid   <= 1'b0;
      result      <= '0;
      hi          <= '0;
      zero        <= 1'b0;
      illegal     <= 1'b0;
      work_hi     <= '0;
      work_lo     <= '0;
      op_q        <= '0;
      count       <= '0;
`ifdef ALU_DIV_EN
      busy_div    <= 1'b0;
`endif
    end else begin
      ready_armed <= 1'b1;
      out_valid   <= (state_next == DONE);
      if (accept) begin
        count <= '0;
        case (dec_op)
          OP_MULTU: begin
            work_hi <= '0;
            work_lo <= b;
            op_q    <= a;
`ifdef ALU_DIV_EN
            busy_div <= 1'b0;
`endif
          end
`ifdef ALU_DIV_EN
          OP_DIVU: begin
            if (b == '0) begin
              result  <= '1;
              hi      <= a;
              zero    <= 1'b0;
              illegal <= 1'b0;
            end else begin
              work_hi  <= '0;
              work_lo  <= a;
              op_q     <= b;
              busy_div <= 1'b1;
            end
          end
`endif
          default: begin
            result  <= alu_res;
            hi      <= '0;
            zero    <= (alu_res == '0);
            illegal <= (dec_op == OP_ILL);
          end
        endcase
      end else if (state == BUSY) begin
        work_hi <= step_hi;
        work_lo <= step_lo;
        count   <= count + CW'(1);
        if (count == LAST_STEP) begin
          result  <= step_lo;
          hi      <= step_hi;
          zero    <= (step_lo == '0);
          illegal <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed expectations for alu_seq
// (WIDTH=32). Expectations for divu follow the ALU_DIV_EN build option.
module tb_alu_seq;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  aluop;
  logic [5:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        illegal;

  int vectors;
  int miscompares;
  int latency;
  logic ready_seen;

  alu_seq dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .func(func), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .hi(hi),
    .zero(zero), .illegal(illegal)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, then count edges (accept edge = 1) until out_valid
  task automatic applyStimulus(input logic [2:0] op, input logic [5:0] fn,
                               input logic [31:0] va, input logic [31:0] vb,
                               input logic [4:0] sh);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("ready_timeout", 64'(in_ready), 64'd1);
    aluop = op; func = fn; a = va; b = vb; shamt = sh;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    latency = 1;
    ready_seen = 1'b0;
    while (!out_valid && latency < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  // Check the presented result and then let the consumer take it
  task automatic checkOp(input string tag, input logic [31:0] exp_res, input logic [31:0] exp_hi,
                         input logic exp_zero, input logic exp_ill, input int exp_lat);
    checkOutput({tag, "_latency"}, 64'(latency), 64'(exp_lat));
    checkOutput({tag, "_result"}, 64'(result), 64'(exp_res));
    checkOutput({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    checkOutput({tag, "_zero"}, 64'(zero), 64'(exp_zero));
    checkOutput({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    resetn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    aluop = '0; func = '0; a = '0; b = '0; shamt = '0;
    latency = 0;
    ready_seen = 1'b0;

    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_zero", 64'(zero), 64'd0);
    checkOutput("rst_illegal", 64'(illegal), 64'd0);

    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

    // Single-cycle ops
    applyStimulus(3'b101, 6'b100010, 32'd5, 32'd7, 5'd0);
    checkOp("sub_func", 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1);
    applyStimulus(3'b100, 6'b000000, 32'hFFFF_FFFF, 32'd1, 5'd0);
    checkOp("slt_neg", 32'h1, 32'h0, 1'b0, 1'b0, 1);
    applyStimulus(3'b110, 6'b000011, 32'h8000_0000, 32'h0, 5'd4);
    checkOp("sra", 32'hF800_0000, 32'h0, 1'b0, 1'b0, 1);
    applyStimulus(3'b000, 6'b111111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    checkOp("add_wrap", 32'h0, 32'h0, 1'b1, 1'b0, 1);
    applyStimulus(3'b010, 6'b000000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    checkOp("and", 32'h0000_F000, 32'h0, 1'b0, 1'b0, 1);
    applyStimulus(3'b011, 6'b000000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    checkOp("or", 32'h0000_FFF0, 32'h0, 1'b0, 1'b0, 1);
    applyStimulus(3'b111, 6'b000000, 32'h1, 32'hFFFF_FFFF, 5'd31);
    checkOp("sll", 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1);
    applyStimulus(3'b101, 6'b000010, 32'h8000_0000, 32'h0, 5'd4);
    checkOp("srl", 32'h0800_0000, 32'h0, 1'b0, 1'b0, 1);
    applyStimulus(3'b101, 6'b101010, 32'd5, 32'hFFFF_FFFF, 5'd0);
    checkOp("slt_func", 32'h0, 32'h0, 1'b1, 1'b0, 1);
    applyStimulus(3'b101, 6'b111111, 32'd9, 32'd9, 5'd0);
    checkOp("illegal", 32'h0, 32'h0, 1'b1, 1'b1, 1);

    // Multiplier
    applyStimulus(3'b101, 6'b011001, 32'hFFFF_FFFF, 32'd2, 5'd0);
    checkOutput("multu_in_ready_busy", 64'(ready_seen), 64'd0);
    checkOp("multu_max", 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 33);
    applyStimulus(3'b110, 6'b011001, 32'h0001_0000, 32'h0001_0000, 5'd0);
    checkOp("multu_pow", 32'h0, 32'h1, 1'b1, 1'b0, 33);
    applyStimulus(3'b111, 6'b011001, 32'd7, 32'd6, 5'd0);
    checkOp("multu_small", 32'd42, 32'h0, 1'b0, 1'b0, 33);

    // Divider or its absence
`ifdef ALU_DIV_EN
    applyStimulus(3'b101, 6'b011011, 32'd100, 32'd7, 5'd0);
    checkOp("divu", 32'd14, 32'd2, 1'b0, 1'b0, 33);
    applyStimulus(3'b101, 6'b011011, 32'd100, 32'd0, 5'd0);
    checkOp("divu_by0", 32'hFFFF_FFFF, 32'd100, 1'b0, 1'b0, 1);
`else
    applyStimulus(3'b101, 6'b011011, 32'd100, 32'd7, 5'd0);
    checkOp("divu_absent", 32'h0, 32'h0, 1'b1, 1'b1, 1);
`endif

    // Consumer stalls in DONE while new requests are offered
    applyStimulus(3'b000, 6'b000000, 32'd3, 32'd4, 5'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      aluop = 3'b001;
      a = 32'd100;
      b = 32'd1;
      @(posedge clk);
      #1;
      checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_result", 64'(result), 64'd7);
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    checkOp("hold_final", 32'd7, 32'h0, 1'b0, 1'b0, 1);

    // Reset pulse in the middle of a multiply
    @(negedge clk);
    aluop = 3'b101; func = 6'b011001; a = 32'd3; b = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    ready_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) ready_seen = 1'b1;
    end
    checkOutput("abort_no_result", 64'(ready_seen), 64'd0);
    checkOutput("abort_in_ready_after", 64'(in_ready), 64'd1);

    applyStimulus(3'b101, 6'b011001, 32'd3, 32'd5, 5'd0);
    checkOp("multu_after_abort", 32'd15, 32'h0, 1'b0, 1'b0, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
